alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//  Parametrised, handshaked successor of the single-cycle execute ALU. Operands are
//  registered and the result is held until the consumer accepts it. Adds unsigned
//  compare, shifts and iterative multiply/divide/remainder.
//  Sits in the EX stage. The pipeline stalls on in_ready=0 or on out_valid && !out_ready.
// PARAMETERS
//  WIDTH  32  operand/result width; power of 2, >= 4
//  SHW    $clog2(WIDTH)  shift-amount width (derived localparam, not overridable)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  in_valid   in   1      operands/sel valid this cycle
//  in_ready   out  1      block can accept a new operation
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B (shift amount = b[SHW-1:0])
//  sel        in   4      operation select (table below)
//  out_valid  out  1      result/zero/dbz valid
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  operation result
//  zero       out  1      result == 0
//  dbz        out  1      last DIVU/REMU had b == 0
//  busy       out  1      iterative op in progress
// BEHAVIOUR
//  Ops: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0111 SLT signed,
//   1000 SLTU, 1001 SLL, 1010 SRL, 1011 SRA, 1100 MUL (low WIDTH bits),
//   1101 DIVU quotient, 1110 REMU. Codes 0101/0110/1111 -> result 0.
//  ADD/SUB wrap modulo 2^WIDTH; no overflow flag. SLT/SLTU give 1 or 0, zero-extended.
//  FSM states: IDLE, BUSY, DONE. Reset -> IDLE. On reset all outputs are 0
//   except in_ready=1.
//  Reset is asynchronous: it aborts any op in flight and drops out_valid immediately.
//  in_ready = (state==IDLE). An operation is accepted when in_valid && in_ready.
//  Accepted a/b/sel are captured. Later changes on a/b/sel are ignored until the
//   next accept.
//  Single-cycle ops: IDLE -> DONE. Accepted at edge t, out_valid=1 after edge t+1
//   (latency 1).
//  MUL/DIVU/REMU: IDLE -> BUSY with counter = WIDTH.
//   Each BUSY cycle does one shift-add step (MUL) or one restoring-divide step
//   (DIV/REM) and decrements the counter. BUSY -> DONE when the counter reaches 0.
//   out_valid is asserted WIDTH+1 cycles after accept. busy=1 only in BUSY.
//  DIVU/REMU with b==0: skip BUSY and go straight to DONE (latency 1).
//   result = all ones (DIVU) or a (REMU); dbz=1. Every other accepted op clears dbz.
//  DONE: out_valid=1; result/zero/dbz stay stable while out_ready=0.
//   out_ready=1 -> IDLE on the next edge, out_valid=0.
//   No new op is accepted in DONE, so the peak rate is 1 op per 2 cycles.
//  zero is computed from the registered result and is valid only with out_valid.
//  in_valid while not in IDLE is ignored. Upstream must hold its request.
//  out_ready while out_valid=0 has no effect.
// TESTING
//  1. ADD a=0xFFFFFFFF b=1 -> result 0, zero=1, out_valid 1 cycle after accept.
//  2. SLT a=0x80000000 b=1 -> 1; SLTU same operands -> 0;
//     SRA a=0x80000000 b=4 -> 0xF8000000.
//  3. MUL a=0x10000 b=0x10001 -> 0x00010000 (low word).
//     out_valid exactly 33 cycles after accept; in_ready=0 and busy=1 in between.
//  4. DIVU a=100 b=7 -> 14; REMU -> 2. DIVU a=5 b=0 -> 0xFFFFFFFF, dbz=1;
//     REMU a=5 b=0 -> 5, dbz=1.
//  5. Hold out_ready=0 for 5 cycles after a result -> result stable, in_ready=0,
//     new in_valid ignored. out_ready=1 -> IDLE next cycle.
//  6. Assert reset mid-MUL (cycle 10 of BUSY) -> out_valid/busy/result 0 at once,
//     in_ready=1. A following ADD 2+3 -> 5. Repeat tests 1-4 with WIDTH=8.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked execute ALU: single-cycle logic/arith ops plus iterative shift-add
// multiply and restoring divide/remainder, result held until the consumer accepts it.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             dbz,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_REMU = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;

  logic             is_mul_s, is_div_s, iterative_s, div_zero_s;
  logic [WIDTH:0]   rem_sh_s;

  // DIVU/REMU only reach this function when the divisor is zero.
  function automatic logic [WIDTH-1:0] alu_single(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
    logic [SHW-1:0] sh;
    sh = y[SHW-1:0];
    case (op)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      OP_SLT:  return {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_SLTU: return {{(WIDTH-1){1'b0}}, (x < y)};
      OP_SLL:  return x << sh;
      OP_SRL:  return x >> sh;
      OP_SRA:  return $signed(x) >>> sh;
      OP_DIVU: return {WIDTH{1'b1}};
      OP_REMU: return x;
      default: return {WIDTH{1'b0}};
    endcase
  endfunction

  // Next-state and next-output computation for the IDLE/BUSY/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    x_d         = x_q;
    y_d         = y_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    zero_d      = zero_q;
    dbz_d       = dbz_q;
    busy_d      = busy_q;
    is_mul_s    = (sel == OP_MUL);
    is_div_s    = (sel == OP_DIVU) || (sel == OP_REMU);
    iterative_s = is_mul_s || is_div_s;
    div_zero_s  = is_div_s && (b == {WIDTH{1'b0}});
    rem_sh_s    = {acc_q, y_q[WIDTH-1]};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Multiply: x=multiplicand, y=multiplier. Divide: x=divisor, y=dividend->quotient.
          op_d       = sel;
          x_d        = is_mul_s ? a : b;
          y_d        = is_mul_s ? b : a;
          acc_d      = {WIDTH{1'b0}};
          cnt_d      = CNT_INIT;
          dbz_d      = div_zero_s;
          in_ready_d = 1'b0;
          if (iterative_s && !div_zero_s) begin
            state_d = BUSY;
            busy_d  = 1'b1;
          end else begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            result_d    = alu_single(sel, a, b);
            zero_d      = (result_d == {WIDTH{1'b0}});
          end
        end else begin
          state_d = IDLE;
        end
      end

      BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (op_q == OP_MUL) begin
          acc_d = y_q[0] ? (acc_q + x_q) : acc_q;
          x_d   = x_q << 1;
          y_d   = y_q >> 1;
        end else if (rem_sh_s >= {1'b0, x_q}) begin
          acc_d = rem_sh_s[WIDTH-1:0] - x_q;
          y_d   = {y_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_sh_s[WIDTH-1:0];
          y_d   = {y_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == CNT_ONE) begin
          state_d     = DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          result_d    = (op_q == OP_DIVU) ? y_d : acc_d;
          zero_d      = (result_d == {WIDTH{1'b0}});
        end else begin
          state_d = BUSY;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= 4'b0000;
      x_q         <= {WIDTH{1'b0}};
      y_q         <= {WIDTH{1'b0}};
      acc_q       <= {WIDTH{1'b0}};
      cnt_q       <= {(SHW+1){1'b0}};
      result_q    <= {WIDTH{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      x_q         <= x_d;
      y_q         <= y_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign dbz       = dbz_q;
  assign busy      = busy_q;

endmodule
